// File: rtl/mult_share_arbiter_tainttrack.sv
// Round-robin arbiter that shares one constant-time, taint-tracked sequential
// multiplier between two requesters. It latches the winner's operands, pulses
// the multiplier start and waits for the product. The product and its taint
// go back to the winner. Every multiplication must take exactly MUL_LAT
// cycles; any other duration, or a watchdog timeout, sets a sticky lat_err.
module mult_share_arbiter_tainttrack #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = WIDTH + 2,
    parameter int TMO     = 2 * MUL_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 req0_t,
    input  logic                 req1_t,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    input  logic [WIDTH-1:0]     a0_t,
    input  logic [WIDTH-1:0]     b0_t,
    input  logic [WIDTH-1:0]     a1_t,
    input  logic [WIDTH-1:0]     b1_t,
    output logic                 done0,
    output logic                 done1,
    output logic                 done0_t,
    output logic                 done1_t,
    output logic [2*WIDTH-1:0]   res,
    output logic [2*WIDTH-1:0]   res_t,
    output logic                 busy,
    output logic                 lat_err,
    output logic                 mul_start,
    output logic                 mul_start_t,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_a_t,
    output logic [WIDTH-1:0]     mul_b_t,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic [2*WIDTH-1:0]   mul_product_t,
    input  logic                 mul_done,
    input  logic                 mul_done_t
);
    localparam int CNT_W = $clog2(TMO + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DELIVER} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               gnt_q, gnt_d;
    logic               gnt_t_q, gnt_t_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done0_q, done0_d, done1_q, done1_d;
    logic               done0_t_q, done0_t_d, done1_t_q, done1_t_d;
    logic [2*WIDTH-1:0] res_q, res_d, res_t_q, res_t_d;
    logic               busy_q, busy_d;
    logic               lat_err_q, lat_err_d;
    logic               mul_start_q, mul_start_d, mul_start_t_q, mul_start_t_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [WIDTH-1:0]   mul_a_t_q, mul_a_t_d, mul_b_t_q, mul_b_t_d;
    logic               win;
    logic               fin_t;

    // Next-state and next-output logic for the arbitration/launch/wait/deliver FSM
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        gnt_d         = gnt_q;
        gnt_t_d       = gnt_t_q;
        cnt_d         = cnt_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        done0_t_d     = 1'b0;
        done1_t_d     = 1'b0;
        res_d         = res_q;
        res_t_d       = res_t_q;
        busy_d        = busy_q;
        lat_err_d     = lat_err_q;
        mul_start_d   = 1'b0;
        mul_start_t_d = 1'b0;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_a_t_d     = mul_a_t_q;
        mul_b_t_d     = mul_b_t_q;
        win           = 1'b0;
        fin_t         = gnt_t_q | mul_done_t;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // With both requesting, the one not served last wins
                    win       = (req0 && req1) ? ~last_q : req1;
                    gnt_d     = win;
                    gnt_t_d   = (req0 && req1) ? (req0_t | req1_t)
                                               : (win ? req1_t : req0_t);
                    mul_a_d   = win ? a1   : a0;
                    mul_b_d   = win ? b1   : b0;
                    mul_a_t_d = win ? a1_t : a0_t;
                    mul_b_t_d = win ? b1_t : b0_t;
                    mul_start_d   = 1'b1;
                    mul_start_t_d = gnt_t_d;
                    busy_d    = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = CNT_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    res_d   = mul_product;
                    res_t_d = mul_product_t | {2*WIDTH{fin_t}};
                    if (cnt_q != LAT_C) begin
                        lat_err_d = 1'b1;
                    end
                    done0_d   = ~gnt_q;
                    done1_d   = gnt_q;
                    done0_t_d = ~gnt_q & fin_t;
                    done1_t_d = gnt_q & fin_t;
                    state_d   = S_DELIVER;
                end else if (cnt_q == TMO_C) begin
                    // Watchdog: the multiplier never answered, return a fully tainted zero
                    lat_err_d = 1'b1;
                    res_d     = '0;
                    res_t_d   = '1;
                    done0_d   = ~gnt_q;
                    done1_d   = gnt_q;
                    done0_t_d = ~gnt_q & fin_t;
                    done1_t_d = gnt_q & fin_t;
                    state_d   = S_DELIVER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DELIVER: begin
                last_d  = gnt_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous active-low reset clears everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            last_q        <= 1'b1;
            gnt_q         <= 1'b0;
            gnt_t_q       <= 1'b0;
            cnt_q         <= '0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            done0_t_q     <= 1'b0;
            done1_t_q     <= 1'b0;
            res_q         <= '0;
            res_t_q       <= '0;
            busy_q        <= 1'b0;
            lat_err_q     <= 1'b0;
            mul_start_q   <= 1'b0;
            mul_start_t_q <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_a_t_q     <= '0;
            mul_b_t_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            gnt_q         <= gnt_d;
            gnt_t_q       <= gnt_t_d;
            cnt_q         <= cnt_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            done0_t_q     <= done0_t_d;
            done1_t_q     <= done1_t_d;
            res_q         <= res_d;
            res_t_q       <= res_t_d;
            busy_q        <= busy_d;
            lat_err_q     <= lat_err_d;
            mul_start_q   <= mul_start_d;
            mul_start_t_q <= mul_start_t_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_a_t_q     <= mul_a_t_d;
            mul_b_t_q     <= mul_b_t_d;
        end
    end

    assign done0       = done0_q;
    assign done1       = done1_q;
    assign done0_t     = done0_t_q;
    assign done1_t     = done1_t_q;
    assign res         = res_q;
    assign res_t       = res_t_q;
    assign busy        = busy_q;
    assign lat_err     = lat_err_q;
    assign mul_start   = mul_start_q;
    assign mul_start_t = mul_start_t_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_a_t     = mul_a_t_q;
    assign mul_b_t     = mul_b_t_q;

endmodule
